// File: rtl/br_pkg.sv
// rtl/br_pkg.sv - shared types and constants for branch resolution and prediction
package br_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } br_state_e;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t BHT_RESET = 2'b01;

endpackage

// File: rtl/bht_2bit.sv
// rtl/bht_2bit.sv - untagged 2-bit saturating counter table, one read port, one update port
module bht_2bit
    import br_pkg::*;
#(
    parameter int BHT_ENTRIES = 64,
    localparam int IW = $clog2(BHT_ENTRIES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [IW-1:0] rd_idx,
    output bht_ctr_t      rd_ctr,
    input  logic          upd_en,
    input  logic [IW-1:0] upd_idx,
    input  logic          upd_taken
);

    bht_ctr_t tbl [BHT_ENTRIES];

    // Read sees the pre-update value when read and write collide.
    assign rd_ctr = tbl[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                tbl[i] <= BHT_RESET;
            end
        end else if (upd_en) begin
            if (upd_taken && tbl[upd_idx] != 2'b11) begin
                tbl[upd_idx] <= tbl[upd_idx] + 2'b01;
            end else if (!upd_taken && tbl[upd_idx] != 2'b00) begin
                tbl[upd_idx] <= tbl[upd_idx] - 2'b01;
            end
        end
    end

endmodule

// File: rtl/br_resolve_ctrl.sv
// rtl/br_resolve_ctrl.sv - BHT prediction, EX branch resolution and one-cycle redirect/flush
// Optional statistics counters are built when BR_STATS_EN is defined.
module br_resolve_ctrl
    import br_pkg::*;
#(
    parameter int BHT_ENTRIES = 64,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pred_pc,
    output logic            pred_taken,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush
`ifdef BR_STATS_EN
    ,
    output logic [31:0]     br_count,
    output logic [31:0]     mispred_count
`endif
);

    localparam int IW = $clog2(BHT_ENTRIES);

    br_state_e       state;
    bht_ctr_t        rd_ctr;
    logic            eq;
    logic            lt_s;
    logic            lt_u;
    logic            taken;
    logic            legal;
    logic            accepted;
    logic            mispredict;
    logic [XLEN-1:0] correct_pc;

    bht_2bit #(
        .BHT_ENTRIES(BHT_ENTRIES)
    ) u_bht (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (pred_pc[IW+1:2]),
        .rd_ctr    (rd_ctr),
        .upd_en    (accepted && legal),
        .upd_idx   (ex_pc[IW+1:2]),
        .upd_taken (taken)
    );

    assign pred_taken = rd_ctr[1];

    assign eq   = (ex_rs1 == ex_rs2);
    assign lt_s = ($signed(ex_rs1) < $signed(ex_rs2));
    assign lt_u = (ex_rs1 < ex_rs2);

    always_comb begin
        taken = 1'b0;
        legal = 1'b1;
        case (ex_funct3)
            F3_BEQ:  taken = eq;
            F3_BNE:  taken = !eq;
            F3_BLT:  taken = lt_s;
            F3_BGE:  taken = !lt_s;
            F3_BLTU: taken = lt_u;
            F3_BGEU: taken = !lt_u;
            default: legal = 1'b0;
        endcase
    end

    // A branch seen while redirecting is on the wrong path and must leave no trace.
    assign accepted   = ex_valid && (state == IDLE);
    assign mispredict = accepted && (taken != ex_pred_taken);
    assign correct_pc = taken ? ex_target : ex_pc + XLEN'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            redirect    <= 1'b0;
            flush       <= 1'b0;
            redirect_pc <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mispredict) begin
                        state       <= REDIRECT;
                        redirect    <= 1'b1;
                        flush       <= 1'b1;
                        redirect_pc <= correct_pc;
                    end
                end
                REDIRECT: begin
                    state    <= IDLE;
                    redirect <= 1'b0;
                    flush    <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    redirect <= 1'b0;
                    flush    <= 1'b0;
                end
            endcase
        end
    end

`ifdef BR_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count      <= '0;
            mispred_count <= '0;
        end else begin
            if (accepted) begin
                br_count <= br_count + 32'd1;
            end
            if (mispredict) begin
                mispred_count <= mispred_count + 32'd1;
            end
        end
    end
`endif

    logic unused_bits;
    assign unused_bits = ^{pred_pc[XLEN-1:IW+2], pred_pc[1:0], ex_pc[1:0], rd_ctr[0]};

endmodule
